// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch port, the data port, the shared memory and
// the arbiter. The arbiter uses modport slave (it is the responder to both
// requesters and the driver of the memory side). A testbench or the
// surrounding system uses modport master.
//   i_*   : instruction-fetch read port (req/addr in, ack/rdata out)
//   d_*   : data read/write port (req/we/addr/wdata in, ack/rdata out)
//   mem_* : shared memory (req/we/addr/wdata out, rdata/ack in)
//   err   : timeout pulse, err_src selects the port (0=fetch, 1=data)
interface mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    logic          err;
    logic          err_src;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_ack, i_rdata, d_ack, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, err, err_src
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_ack, i_rdata, d_ack, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, err, err_src
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single memory. It takes a fetch port and a
// data port, with round-robin on ties, and runs one access at a time. Each
// grant aborts after TIMEOUT cycles without mem_ack. In that case it acks
// the port with zero data and pulses err.
// Ports: clk, rst_n (synchronous, active-low), bus (mem_arbiter_if.slave).
// All outputs are registered.
module mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    state_t        state_q, state_d;
    logic          last_d_q, last_d_d;    // 1: data port was granted last
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          err_q, err_d;
    logic          err_src_q, err_src_d;

    logic          i_elig_c, d_elig_c, done_c, abort_c;
    logic [DW-1:0] rdata_c;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        err_d       = 1'b0;
        err_src_d   = err_src_q;

        // A port whose ack is showing this cycle has not yet seen it, so
        // its still-high req must not start a second access.
        i_elig_c = bus.i_req && !i_ack_q;
        d_elig_c = bus.d_req && !d_ack_q;
        done_c   = 1'b0;
        abort_c  = 1'b0;
        rdata_c  = '0;

        case (state_q)
            IDLE: begin
                if (d_elig_c && (!i_elig_c || !last_d_q)) begin
                    state_d     = GRANT_D;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                end else if (i_elig_c) begin
                    state_d     = GRANT_I;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.i_addr;
                    mem_wdata_d = '0;
                end
            end
            GRANT_I, GRANT_D: begin
                if (bus.mem_ack) begin
                    done_c  = 1'b1;
                    rdata_c = mem_we_q ? '0 : bus.mem_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    done_c  = 1'b1;
                    abort_c = 1'b1;
                    cnt_d   = cnt_q + CW'(1);
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Common completion path for normal end and timeout
        if (done_c) begin
            state_d     = IDLE;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            last_d_d    = (state_q == GRANT_D);
            err_d       = abort_c;
            if (abort_c) begin
                err_src_d = (state_q == GRANT_D);
            end
            if (state_q == GRANT_D) begin
                d_ack_d   = 1'b1;
                d_rdata_d = rdata_c;
            end else begin
                i_ack_d   = 1'b1;
                i_rdata_d = rdata_c;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
            err_src_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
            err_src_q   <= err_src_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.err       = err_q;
    assign bus.err_src   = err_src_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter. Each row gives the inputs
// applied before one rising edge and the registered outputs expected after it.
module tb_mem_arbiter;
    typedef struct packed {
        logic        rst_n;
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        mem_ack;
        logic [31:0] mem_rdata;
    } in_t;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        i_ack;
        logic [31:0] i_rdata;
        logic        d_ack;
        logic [31:0] d_rdata;
        logic        err;
        logic        err_src;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic in_t fi(logic rst, logic ireq, logic [31:0] iaddr,
                               logic dreq, logic dwe, logic [31:0] daddr,
                               logic [31:0] dwdata, logic mack, logic [31:0] mrdata);
        in_t r;
        r.rst_n = rst;   r.i_req = ireq;  r.i_addr = iaddr;
        r.d_req = dreq;  r.d_we = dwe;    r.d_addr = daddr;
        r.d_wdata = dwdata; r.mem_ack = mack; r.mem_rdata = mrdata;
        return r;
    endfunction

    function automatic out_t fo(logic mreq, logic mwe, logic [31:0] maddr,
                                logic [31:0] mwdata, logic iack, logic [31:0] irdata,
                                logic dack, logic [31:0] drdata, logic e, logic esrc);
        out_t r;
        r.mem_req = mreq; r.mem_we = mwe; r.mem_addr = maddr; r.mem_wdata = mwdata;
        r.i_ack = iack;   r.i_rdata = irdata; r.d_ack = dack; r.d_rdata = drdata;
        r.err = e;        r.err_src = esrc;
        return r;
    endfunction

    // Drive one row, clock it, compare all outputs plus the ack/err invariant.
    task automatic run_row(input in_t x, input out_t e, input string tag, input int idx);
        out_t got;
        @(negedge clk);
        rst_n         = x.rst_n;
        bus.i_req     = x.i_req;
        bus.i_addr    = x.i_addr;
        bus.d_req     = x.d_req;
        bus.d_we      = x.d_we;
        bus.d_addr    = x.d_addr;
        bus.d_wdata   = x.d_wdata;
        bus.mem_ack   = x.mem_ack;
        bus.mem_rdata = x.mem_rdata;
        @(posedge clk);
        #1;
        got = fo(bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.i_ack,
                 bus.i_rdata, bus.d_ack, bus.d_rdata, bus.err, bus.err_src);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s[%0d] got req=%b we=%b addr=%h wd=%h iack=%b ird=%h dack=%b drd=%h err=%b src=%b | exp req=%b we=%b addr=%h wd=%h iack=%b ird=%h dack=%b drd=%h err=%b src=%b",
                     tag, idx, got.mem_req, got.mem_we, got.mem_addr, got.mem_wdata,
                     got.i_ack, got.i_rdata, got.d_ack, got.d_rdata, got.err, got.err_src,
                     e.mem_req, e.mem_we, e.mem_addr, e.mem_wdata,
                     e.i_ack, e.i_rdata, e.d_ack, e.d_rdata, e.err, e.err_src);
        end
        checks++;
        if ((got.i_ack && got.d_ack) || (got.err && !(got.i_ack || got.d_ack))) begin
            errors++;
            $display("FAIL ack_onehot %s[%0d] got iack=%b dack=%b err=%b required at most one ack, err only with ack",
                     tag, idx, got.i_ack, got.d_ack, got.err);
        end
    endtask

    // Repeat the same row n times (long waits inside a grant).
    task automatic run_rep(input in_t x, input out_t e, input string tag, input int n);
        for (int k = 0; k < n; k++) run_row(x, e, tag, k);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        bus.d_addr = '0;  bus.d_wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;

        // Single fetch, then a stray mem_ack while idle
        tbl.push_back({fi(0,0,0,0,0,0,0,0,0),          fo(0,0,0,0,0,0,0,0,0,0)});
        tbl.push_back({fi(1,1,32'h10,0,0,0,0,0,0),     fo(1,0,32'h10,0,0,0,0,0,0,0)});
        tbl.push_back({fi(1,1,32'h10,0,0,0,0,1,32'hDEADBEEF), fo(0,0,0,0,1,32'hDEADBEEF,0,0,0,0)});
        tbl.push_back({fi(1,0,0,0,0,0,0,0,0),          fo(0,0,0,0,0,32'hDEADBEEF,0,0,0,0)});
        tbl.push_back({fi(1,0,0,0,0,0,0,1,32'h99),     fo(0,0,0,0,0,32'hDEADBEEF,0,0,0,0)});
        // Reset, then held ties alternate D, I, D, I
        tbl.push_back({fi(0,0,0,0,0,0,0,0,0),          fo(0,0,0,0,0,0,0,0,0,0)});
        tbl.push_back({fi(1,1,32'h10,1,0,32'h20,0,0,0),     fo(1,0,32'h20,0,0,0,0,0,0,0)});
        tbl.push_back({fi(1,1,32'h10,1,0,32'h20,0,1,32'hA1), fo(0,0,0,0,0,0,1,32'hA1,0,0)});
        tbl.push_back({fi(1,1,32'h10,1,0,32'h20,0,0,0),     fo(1,0,32'h10,0,0,0,0,32'hA1,0,0)});
        tbl.push_back({fi(1,1,32'h10,1,0,32'h20,0,1,32'hB2), fo(0,0,0,0,1,32'hB2,0,32'hA1,0,0)});
        tbl.push_back({fi(1,1,32'h10,1,0,32'h20,0,0,0),     fo(1,0,32'h20,0,0,32'hB2,0,32'hA1,0,0)});
        tbl.push_back({fi(1,1,32'h10,1,0,32'h20,0,1,32'hC3), fo(0,0,0,0,0,32'hB2,1,32'hC3,0,0)});
        tbl.push_back({fi(1,1,32'h10,1,0,32'h20,0,0,0),     fo(1,0,32'h10,0,0,32'hB2,0,32'hC3,0,0)});
        tbl.push_back({fi(1,1,32'h10,1,0,32'h20,0,1,32'hD4), fo(0,0,0,0,1,32'hD4,0,32'hC3,0,0)});
        tbl.push_back({fi(1,0,0,0,0,0,0,0,0),          fo(0,0,0,0,0,32'hD4,0,32'hC3,0,0)});
        // Write with mem_ack three cycles late; d_req dropped mid-grant
        tbl.push_back({fi(1,0,0,1,1,32'h4,32'h55,0,0), fo(1,1,32'h4,32'h55,0,32'hD4,0,32'hC3,0,0)});
        tbl.push_back({fi(1,0,0,1,1,32'h4,32'h55,0,0), fo(1,1,32'h4,32'h55,0,32'hD4,0,32'hC3,0,0)});
        tbl.push_back({fi(1,0,0,0,0,0,0,0,0),          fo(1,1,32'h4,32'h55,0,32'hD4,0,32'hC3,0,0)});
        tbl.push_back({fi(1,0,0,0,0,0,0,0,0),          fo(1,1,32'h4,32'h55,0,32'hD4,0,32'hC3,0,0)});
        tbl.push_back({fi(1,0,0,0,0,0,0,1,32'hFFFF),   fo(0,0,0,0,0,32'hD4,1,0,0,0)});
        tbl.push_back({fi(1,0,0,0,0,0,0,0,0),          fo(0,0,0,0,0,32'hD4,0,0,0,0)});

        for (int n = 0; n < tbl.size(); n++) run_row(tbl[n].in, tbl[n].exp, "tbl", n);

        // Fetch timeout: 15 grant cycles, then ack with zero data and err
        run_rep(fi(1,1,32'h40,0,0,0,0,0,0), fo(1,0,32'h40,0,0,32'hD4,0,0,0,0), "to_i_wait", 15);
        run_row(fi(1,1,32'h40,0,0,0,0,0,0), fo(0,0,0,0,1,0,0,0,1,0), "to_i_err", 0);
        run_row(fi(1,1,32'h40,0,0,0,0,0,0), fo(0,0,0,0,0,0,0,0,0,0), "to_i_noregrant", 0);
        run_row(fi(1,0,0,0,0,0,0,0,0),      fo(0,0,0,0,0,0,0,0,0,0), "to_i_idle", 0);

        // Data read acked on the 15th grant cycle: normal, no err
        run_rep(fi(1,0,0,1,0,32'h80,0,0,0), fo(1,0,32'h80,0,0,0,0,0,0,0), "ack15_wait", 15);
        run_row(fi(1,0,0,1,0,32'h80,0,1,32'h1234), fo(0,0,0,0,0,0,1,32'h1234,0,0), "ack15_done", 0);
        run_row(fi(1,0,0,0,0,0,0,0,0),      fo(0,0,0,0,0,0,0,32'h1234,0,0), "ack15_idle", 0);

        // Data write timeout reports err_src=1
        run_rep(fi(1,0,0,1,1,32'h8,32'hAA,0,0), fo(1,1,32'h8,32'hAA,0,0,0,32'h1234,0,0), "to_d_wait", 15);
        run_row(fi(1,0,0,0,0,0,0,0,0),      fo(0,0,0,0,0,0,1,0,1,1), "to_d_err", 0);
        run_row(fi(1,0,0,0,0,0,0,0,0),      fo(0,0,0,0,0,0,0,0,0,1), "to_d_idle", 0);

        // Reset mid GRANT_D: access dropped, held req granted again after release
        run_row(fi(1,0,0,1,0,32'h30,0,0,0), fo(1,0,32'h30,0,0,0,0,0,0,1), "rst_grant", 0);
        run_row(fi(0,0,0,1,0,32'h30,0,1,32'h66), fo(0,0,0,0,0,0,0,0,0,0), "rst_assert", 0);
        run_row(fi(1,0,0,1,0,32'h30,0,0,0), fo(1,0,32'h30,0,0,0,0,0,0,0), "rst_regrant", 0);
        run_row(fi(1,0,0,1,0,32'h30,0,1,32'h77), fo(0,0,0,0,0,0,1,32'h77,0,0), "rst_done", 0);
        run_row(fi(1,0,0,0,0,0,0,0,0),      fo(0,0,0,0,0,0,0,32'h77,0,0), "rst_idle", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
